// File: rtl/mips_pkg.sv
// Shared types for the MIPS data-memory responder: access sizes, FSM states, latched request.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        DMEM_IDLE   = 2'b00,
        DMEM_ACCESS = 2'b01,
        DMEM_RESP   = 2'b10
    } dmem_state_t;

    localparam int DMEM_WAIT_CNT_WIDTH = 4;

    // Request fields the lane logic needs; the word index is kept separately
    // because its width follows DEPTH_WORDS.
    typedef struct packed {
        logic        write;
        mem_size_t   size;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } dmem_op_t;

endpackage

// File: rtl/mips_dmem_lane.sv
// Byte-lane steering: byte enables, replicated store data, extracted load data, misalign flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mips_dmem_lane
    import mips_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata     = 32'h0;
        misalign  = 1'b0;
        shifted   = word >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                misalign  = addr_lo[0];
                byte_en   = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {16'h0, shifted[15:0]};
            end
            // Encoding 2'b11 is deliberately handled as a full word.
            default: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                wdata_rep = wdata;
                rdata     = word;
            end
        endcase
        if (misalign) begin
            byte_en = 4'b0000;
            rdata   = 32'h0;
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS load/store path; optional counters under MIPS_DMEM_ACCESS_CNT_EN.
// Latency: accept at edge T -> rsp_valid in cycle T+1+WAIT_STATES; one outstanding request.
// Backpressure: req_ready only in IDLE; stall holds the PC while a request is pending.
module mips_dmem_responder
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  misalign_err,
    output logic                  stall
`ifdef MIPS_DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]           ld_count,
    output logic [31:0]           st_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_WAIT_CNT_WIDTH-1:0] WAIT_LAST =
        (WAIT_STATES == 0) ? '0 : DMEM_WAIT_CNT_WIDTH'(WAIT_STATES - 1);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mips_dmem_responder: DATA_WIDTH must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("mips_dmem_responder: WAIT_STATES must be 0..15");
    end
    if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
        $error("mips_dmem_responder: DEPTH_WORDS must be a power of 2");
    end

    dmem_state_t                    state, state_nxt;
    logic [DMEM_WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;
    logic                           accept;
    logic                           enter_resp;

    dmem_op_t                       op_q, op;
    logic [IDX_W-1:0]               idx_q, op_idx;

    logic [31:0]                    mem [DEPTH_WORDS];
    logic [31:0]                    cur_word;
    logic [3:0]                     lane_be;
    logic [31:0]                    lane_wdata;
    logic [31:0]                    lane_rdata;
    logic                           lane_misalign;

    logic                           unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

    // FSM next-state and handshake outputs
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_ready    = 1'b0;
        stall        = 1'b0;
        accept       = 1'b0;
        enter_resp   = 1'b0;
        case (state)
            DMEM_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = '0;
                    if (WAIT_STATES == 0) begin
                        state_nxt  = DMEM_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt  = DMEM_ACCESS;
                    end
                end
            end
            DMEM_ACCESS: begin
                stall = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = DMEM_RESP;
                    enter_resp   = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            DMEM_RESP: begin
                state_nxt = DMEM_IDLE;
            end
            default: begin
                state_nxt = DMEM_IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == DMEM_RESP);

    // With zero wait states the access happens on the accept edge, so the
    // lane logic must see the live request rather than the latched copy.
    always_comb begin
        if (state == DMEM_IDLE) begin
            op.write   = req_write;
            op.size    = mem_size_t'(req_size);
            op.addr_lo = req_addr[1:0];
            op.wdata   = req_wdata;
            op_idx     = req_addr[2 +: IDX_W];
        end else begin
            op     = op_q;
            op_idx = idx_q;
        end
    end

    assign cur_word = mem[op_idx];

    mips_dmem_lane u_lane (
        .size      (op.size),
        .addr_lo   (op.addr_lo),
        .wdata     (op.wdata),
        .word      (cur_word),
        .byte_en   (lane_be),
        .wdata_rep (lane_wdata),
        .rdata     (lane_rdata),
        .misalign  (lane_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DMEM_IDLE;
            wait_cnt     <= '0;
            rsp_rdata    <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            rsp_rdata    <= (enter_resp && !op.write) ? lane_rdata : '0;
            misalign_err <= enter_resp && lane_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q.write   <= req_write;
            op_q.size    <= mem_size_t'(req_size);
            op_q.addr_lo <= req_addr[1:0];
            op_q.wdata   <= req_wdata;
            idx_q        <= req_addr[2 +: IDX_W];
        end
    end

    // A store caught by reset on its commit edge is dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && op.write && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem[op_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MIPS_DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_count <= '0;
            st_count <= '0;
        end else if (rsp_valid && !misalign_err) begin
            if (op_q.write) begin
                if (st_count != 32'hFFFF_FFFF) st_count <= st_count + 1'b1;
            end else begin
                if (ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 1'b1;
            end
        end
    end
`endif

endmodule
